// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-port arbiter in front of a single synchronous memory port.
//   Port 0 (CPU) has fixed priority over port 1 (loader), except that
//   port 1 is forced through after STARVE_LIMIT consecutive port-0 wins
//   that happened while port 1 was waiting.
//
//   Each access goes through IDLE -> ISSUE (-> RESP for reads) -> IDLE.
//   The memory command (mem_we/mem_addr/mem_wdata) is registered when the
//   winner is chosen, so it is presented to the memory during ISSUE.
//   Read data comes back one cycle later and is routed to the winner in RESP.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   pN_req/we/addr/wdata  request side of port N (N = 0 CPU, 1 loader)
//   pN_gnt                one-cycle pulse, request issued to memory
//   pN_rvalid/pN_rdata    one-cycle read response for port N
//   mem_we/addr/wdata     registered memory command
//   mem_rdata             memory read data (valid the cycle after ISSUE)
//   busy                  high whenever the FSM is not IDLE
//   dbg_state             current FSM state (IDLE=0, ISSUE=1, RESP=2)
//   dbg_starve_cnt        current starvation counter
//
// Handshake: pN_req is the valid, held stable (with we/addr/wdata) until
// pN_gnt. pN_gnt is the ready, a single-cycle pulse; the request is consumed
// in that cycle. A request dropped before it is sampled in IDLE is withdrawn;
// once sampled it always completes.
module mem_port_arbiter #(
    parameter int AW           = 8,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [1:0]    dbg_state,
    output logic [3:0]    dbg_starve_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    state_t        state_q, state_d;
    logic          winner_q, winner_d;       // 0 = port 0, 1 = port 1
    logic [3:0]    starve_cnt_q, starve_cnt_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          pick_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            winner_q     <= 1'b0;
            starve_cnt_q <= 4'd0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            starve_cnt_q <= starve_cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Port 1 wins if it is the only requester, or if port 0 has used up
    // its allowance of consecutive wins over a waiting port 1.
    assign pick_p1 = p1_req && (!p0_req || (starve_cnt_q == LIMIT_C));

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        starve_cnt_d = starve_cnt_q;
        mem_we_d     = 1'b0;          // write enable lives only in ISSUE
        mem_addr_d   = mem_addr_q;    // address/data hold through RESP
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    winner_d = pick_p1;
                    state_d  = ISSUE;
                    if (pick_p1) begin
                        starve_cnt_d = 4'd0;
                        mem_we_d     = p1_we;
                        mem_addr_d   = p1_addr;
                        mem_wdata_d  = p1_wdata;
                    end else begin
                        // Count only wins that kept port 1 waiting.
                        if (!p1_req) begin
                            starve_cnt_d = 4'd0;
                        end else if (starve_cnt_q >= LIMIT_C) begin
                            starve_cnt_d = LIMIT_C;
                        end else begin
                            starve_cnt_d = starve_cnt_q + 4'd1;
                        end
                        mem_we_d    = p0_we;
                        mem_addr_d  = p0_addr;
                        mem_wdata_d = p0_wdata;
                    end
                end
            end
            ISSUE: begin
                state_d = mem_we_q ? IDLE : RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant/response pulses are decoded straight from the state flops so
    // that reset removes them immediately.
    assign p0_gnt    = (state_q == ISSUE) && !winner_q;
    assign p1_gnt    = (state_q == ISSUE) &&  winner_q;
    assign p0_rvalid = (state_q == RESP)  && !winner_q;
    assign p1_rvalid = (state_q == RESP)  &&  winner_q;
    assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
    assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign busy           = (state_q != IDLE);
    assign dbg_state      = state_q;
    assign dbg_starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        p0_req, p0_we, p1_req, p1_we;
  logic [7:0]  p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [15:0] p0_rdata, p1_rdata;
  logic        mem_we, busy;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_starve_cnt;

  mem_port_arbiter #(.AW(8), .DW(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // synchronous memory model: read data one cycle after address
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'h10] <= 16'hBEEF;
      mem_rdata  <= 16'h0000;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic q0, w0; logic [7:0] a0; logic [15:0] d0;
    logic q1, w1; logic [7:0] a1; logic [15:0] d1;
    logic g0, r0; logic [15:0] rd0;
    logic g1, r1; logic [15:0] rd1;
    logic b, mw; logic [7:0] ea; logic [15:0] ed; logic [3:0] cnt;
  } vec_t;

  vec_t vt [19];

  task automatic drive(input logic q0, w0, input logic [7:0] a0, input logic [15:0] d0,
                       input logic q1, w1, input logic [7:0] a1, input logic [15:0] d1);
    p0_req = q0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = q1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " p0_gnt"}, 32'(p0_gnt), 32'(L));
    chk({tag, " p1_gnt"}, 32'(p1_gnt), 32'(L));
    chk({tag, " p0_rvalid"}, 32'(p0_rvalid), 32'(L));
    chk({tag, " p1_rvalid"}, 32'(p1_rvalid), 32'(L));
  endtask

  initial begin
    int got;
    logic exp_p1;

    drive(L, L, 8'h00, 16'h0000, L, L, 8'h00, 16'h0000);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    chk("reset busy", 32'(busy), 32'(L));
    chk("reset mem_we", 32'(mem_we), 32'(L));
    chk("reset mem_addr", 32'(mem_addr), 32'h0);
    chk("reset mem_wdata", 32'(mem_wdata), 32'h0);
    chk("reset state", 32'(dbg_state), 32'h0);
    chk("reset starve_cnt", 32'(dbg_starve_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    //         q0 w0 a0     d0        q1 w1 a1     d1         g0 r0 rd0       g1 r1 rd1       b  mw ea     ed        cnt
    // p0 read of 0x10 (holds BEEF)
    vt[0]  = '{H, L, 8'h10, 16'h0000, L, L, 8'h00, 16'h0000, H, L, 16'h0000, L, L, 16'h0000, H, L, 8'h10, 16'h0000, 4'd0};
    vt[1]  = '{L, L, 8'h00, 16'h0000, L, L, 8'h00, 16'h0000, L, H, 16'hBEEF, L, L, 16'h0000, H, L, 8'h10, 16'h0000, 4'd0};
    vt[2]  = '{L, L, 8'h00, 16'h0000, L, L, 8'h00, 16'h0000, L, L, 16'h0000, L, L, 16'h0000, L, L, 8'h10, 16'h0000, 4'd0};
    // p1 write 0x20 <= 1234
    vt[3]  = '{L, L, 8'h00, 16'h0000, H, H, 8'h20, 16'h1234, L, L, 16'h0000, H, L, 16'h0000, H, H, 8'h20, 16'h1234, 4'd0};
    vt[4]  = '{L, L, 8'h00, 16'h0000, L, L, 8'h00, 16'h0000, L, L, 16'h0000, L, L, 16'h0000, L, L, 8'h20, 16'h1234, 4'd0};
    // p0 reads back 0x20
    vt[5]  = '{H, L, 8'h20, 16'h0000, L, L, 8'h00, 16'h0000, H, L, 16'h0000, L, L, 16'h0000, H, L, 8'h20, 16'h0000, 4'd0};
    vt[6]  = '{L, L, 8'h00, 16'h0000, L, L, 8'h00, 16'h0000, L, H, 16'h1234, L, L, 16'h0000, H, L, 8'h20, 16'h0000, 4'd0};
    vt[7]  = '{L, L, 8'h00, 16'h0000, L, L, 8'h00, 16'h0000, L, L, 16'h0000, L, L, 16'h0000, L, L, 8'h20, 16'h0000, 4'd0};
    // simultaneous reads: p0 first, p1 granted 3 cycles later
    vt[8]  = '{H, L, 8'h10, 16'h0000, H, L, 8'h20, 16'h0000, H, L, 16'h0000, L, L, 16'h0000, H, L, 8'h10, 16'h0000, 4'd1};
    vt[9]  = '{L, L, 8'h00, 16'h0000, H, L, 8'h20, 16'h0000, L, H, 16'hBEEF, L, L, 16'h0000, H, L, 8'h10, 16'h0000, 4'd1};
    vt[10] = '{L, L, 8'h00, 16'h0000, H, L, 8'h20, 16'h0000, L, L, 16'h0000, L, L, 16'h0000, L, L, 8'h10, 16'h0000, 4'd1};
    vt[11] = '{L, L, 8'h00, 16'h0000, H, L, 8'h20, 16'h0000, L, L, 16'h0000, H, L, 16'h0000, H, L, 8'h20, 16'h0000, 4'd0};
    vt[12] = '{L, L, 8'h00, 16'h0000, L, L, 8'h00, 16'h0000, L, L, 16'h0000, L, H, 16'h1234, H, L, 8'h20, 16'h0000, 4'd0};
    vt[13] = '{L, L, 8'h00, 16'h0000, L, L, 8'h00, 16'h0000, L, L, 16'h0000, L, L, 16'h0000, L, L, 8'h20, 16'h0000, 4'd0};
    // p1 pulses req only during the RESP of a p0 read: withdrawn, never granted
    vt[14] = '{H, L, 8'h10, 16'h0000, L, L, 8'h00, 16'h0000, H, L, 16'h0000, L, L, 16'h0000, H, L, 8'h10, 16'h0000, 4'd0};
    vt[15] = '{L, L, 8'h00, 16'h0000, L, L, 8'h00, 16'h0000, L, H, 16'hBEEF, L, L, 16'h0000, H, L, 8'h10, 16'h0000, 4'd0};
    vt[16] = '{L, L, 8'h00, 16'h0000, H, L, 8'h40, 16'h0000, L, L, 16'h0000, L, L, 16'h0000, L, L, 8'h10, 16'h0000, 4'd0};
    vt[17] = '{L, L, 8'h00, 16'h0000, L, L, 8'h00, 16'h0000, L, L, 16'h0000, L, L, 16'h0000, L, L, 8'h10, 16'h0000, 4'd0};
    vt[18] = '{L, L, 8'h00, 16'h0000, L, L, 8'h00, 16'h0000, L, L, 16'h0000, L, L, 16'h0000, L, L, 8'h10, 16'h0000, 4'd0};

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vt[i].q0, vt[i].w0, vt[i].a0, vt[i].d0, vt[i].q1, vt[i].w1, vt[i].a1, vt[i].d1);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d p0_gnt", i), 32'(p0_gnt), 32'(vt[i].g0));
      chk($sformatf("v%0d p0_rvalid", i), 32'(p0_rvalid), 32'(vt[i].r0));
      if (vt[i].r0) chk($sformatf("v%0d p0_rdata", i), 32'(p0_rdata), 32'(vt[i].rd0));
      chk($sformatf("v%0d p1_gnt", i), 32'(p1_gnt), 32'(vt[i].g1));
      chk($sformatf("v%0d p1_rvalid", i), 32'(p1_rvalid), 32'(vt[i].r1));
      if (vt[i].r1) chk($sformatf("v%0d p1_rdata", i), 32'(p1_rdata), 32'(vt[i].rd1));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vt[i].b));
      chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vt[i].mw));
      chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vt[i].ea));
      chk($sformatf("v%0d mem_wdata", i), 32'(mem_wdata), 32'(vt[i].ed));
      chk($sformatf("v%0d starve_cnt", i), 32'(dbg_starve_cnt), 32'(vt[i].cnt));
    end

    // both ports hold write requests: p0,p0,p0,p0,p1 repeating
    @(negedge clk);
    drive(H, H, 8'h50, 16'hAAAA, H, H, 8'h60, 16'h5555);
    got = 0;
    for (int cyc = 0; cyc < 100 && got < 15; cyc++) begin
      @(posedge clk);
      #1;
      if (p0_gnt || p1_gnt) begin
        exp_p1 = ((got % 5) == 4);
        chk($sformatf("starve g%0d p1_gnt", got), 32'(p1_gnt), 32'(exp_p1));
        chk($sformatf("starve g%0d p0_gnt", got), 32'(p0_gnt), 32'(!exp_p1));
        chk($sformatf("starve g%0d mem_we", got), 32'(mem_we), 32'(H));
        chk($sformatf("starve g%0d mem_addr", got), 32'(mem_addr), exp_p1 ? 32'h60 : 32'h50);
        got++;
      end
    end
    if (got < 15) chk("starve grant timeout", 32'(got), 32'd15);
    @(negedge clk);
    drive(L, L, 8'h00, 16'h0000, L, L, 8'h00, 16'h0000);
    repeat (2) @(posedge clk);

    // reset lands in the ISSUE cycle of a p0 write (p1 waiting, cnt=1)
    @(negedge clk);
    drive(H, H, 8'h30, 16'h7777, H, L, 8'h40, 16'h0000);
    @(posedge clk);
    #1;
    chk("rst pre p0_gnt", 32'(p0_gnt), 32'(H));
    chk("rst pre mem_we", 32'(mem_we), 32'(H));
    chk("rst pre starve_cnt", 32'(dbg_starve_cnt), 32'd1);
    reset = 1'b1;
    #1;
    chk_quiet("rst abort");
    chk("rst abort mem_we", 32'(mem_we), 32'(L));
    chk("rst abort busy", 32'(busy), 32'(L));
    chk("rst abort starve_cnt", 32'(dbg_starve_cnt), 32'd0);
    chk("rst abort mem_addr", 32'(mem_addr), 32'h0);
    chk("rst abort mem_wdata", 32'(mem_wdata), 32'h0);
    @(negedge clk);
    drive(L, L, 8'h00, 16'h0000, L, L, 8'h00, 16'h0000);
    @(posedge clk);
    #1;
    chk_quiet("rst held");
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk_quiet($sformatf("post rst c%0d", c));
      chk($sformatf("post rst c%0d busy", c), 32'(busy), 32'(L));
    end

    // first request after reset: p1 reads 0x30, which the aborted write never touched
    @(negedge clk);
    drive(L, L, 8'h00, 16'h0000, H, L, 8'h30, 16'h0000);
    @(posedge clk);
    #1;
    chk("post rst p1_gnt", 32'(p1_gnt), 32'(H));
    chk("post rst p1_gnt mem_addr", 32'(mem_addr), 32'h30);
    @(negedge clk);
    drive(L, L, 8'h00, 16'h0000, L, L, 8'h00, 16'h0000);
    @(posedge clk);
    #1;
    chk("post rst p1_rvalid", 32'(p1_rvalid), 32'(H));
    chk("post rst p1_rdata", 32'(p1_rdata), 32'h0000);
    @(posedge clk);
    #1;
    chk_quiet("end idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 8, meaning memory address width.
REQ-002 The block SHALL have parameter DW, default 16, meaning memory data width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum consecutive port-0 grants while port 1 is waiting (range 1..15).
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pN_req  input  1  (N=0 CPU, N=1 loader) access request, held until pN_gnt.
REQ-007 pN_we  input  1  1=write, 0=read; held with pN_req.
REQ-008 pN_addr  input  AW  access address; held with pN_req.
REQ-009 pN_wdata  input  DW  write data; held with pN_req.
REQ-010 pN_gnt  output  1  one-cycle pulse: request accepted and issued to memory this cycle.
REQ-011 pN_rvalid  output  1  one-cycle pulse: pN_rdata valid for the granted read.
REQ-012 pN_rdata  output  DW  read data; routed from mem_rdata, meaningful only while pN_rvalid=1.
REQ-013 mem_we  output  1  registered write enable to memory.
REQ-014 mem_addr  output  AW  registered memory address.
REQ-015 mem_wdata  output  DW  registered memory write data.
REQ-016 mem_rdata  input  DW  memory read data, valid in the cycle after a read is issued.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE and RESP.
REQ-019 IDLE: if any pN_req=1 on a posedge, the block SHALL latch the winner, load mem_we/mem_addr/mem_wdata from that port, and enter ISSUE.
REQ-020 ISSUE: the block SHALL assert the winner's pN_gnt for exactly this one cycle, go to IDLE if it is a write, and go to RESP if it is a read.
REQ-021 RESP: the block SHALL assert the winner's pN_rvalid with pN_rdata=mem_rdata for exactly one cycle, then go to IDLE.
REQ-022 Request sampling edge to gnt SHALL be 1 cycle; read sampling edge to rvalid SHALL be 2 cycles.
REQ-023 Arbitration SHALL occur only in IDLE; minimum occupancy SHALL be 2 cycles per write and 3 cycles per read.
REQ-024 Priority SHALL be fixed to port 0, except when both ports request and starve_cnt==STARVE_LIMIT, in which case port 1 SHALL win.
REQ-025 starve_cnt (4 bits) SHALL increment when port 0 wins while p1_req=1.
REQ-026 starve_cnt SHALL clear when port 1 wins, or when an arbitration occurs with p1_req=0.
REQ-027 starve_cnt SHALL saturate at STARVE_LIMIT and never wrap.
REQ-028 mem_we SHALL be 1 only during ISSUE of a write and SHALL be 0 in all other states.
REQ-029 mem_addr and mem_wdata SHALL hold their values through RESP.
REQ-030 Signal pairs: pN_gnt and pN_rvalid SHALL never both be high in the same cycle for the same port; the two ports SHALL never receive gnt or rvalid in the same cycle.
REQ-031 A pN_req deasserted before its gnt SHALL be treated as withdrawn; the block SHALL not issue it if it has not yet been sampled in IDLE.
REQ-032 A request already latched SHALL complete regardless of later pN_req changes.
REQ-033 A new request from the just-served port, sampled in IDLE, SHALL be arbitrated normally, with no extra idle cycle.

Reset
REQ-034 While reset=1, the block SHALL force state=IDLE, starve_cnt=0, and all outputs to 0 (gnt, rvalid, rdata, mem_we, mem_addr, mem_wdata, busy), independent of clk.
REQ-035 Reset asserted during ISSUE or RESP SHALL abort the access: no gnt or rvalid pulse follows, and mem_we drops immediately.
REQ-036 After reset deassertion, the first arbitration SHALL occur on the first posedge with a pN_req high.

Verification
REQ-037 The bench SHALL cover: p0 read addr 8'h10 with memory holding 16'hBEEF -> p0_gnt at cycle +1, p0_rvalid with p0_rdata=16'hBEEF at cycle +2, busy high for 2 cycles.
REQ-038 The bench SHALL cover: p1 write addr 8'h20 data 16'h1234 -> p1_gnt at +1 with mem_we=1, mem_addr=8'h20, mem_wdata=16'h1234 in that cycle only, and no p1_rvalid.
REQ-039 The bench SHALL cover: p0 and p1 continuously requesting writes, STARVE_LIMIT=4 -> grant sequence p0,p0,p0,p0,p1, repeating.
REQ-040 The bench SHALL cover: simultaneous p0 read and p1 read from IDLE with starve_cnt=0 -> p0 served first, p1_gnt 3 cycles after p0_gnt.
REQ-041 The bench SHALL cover: reset asserted in the ISSUE cycle of a p0 write -> mem_we=0 immediately, no p0_gnt or rvalid, busy=0, starve_cnt=0.
REQ-042 The bench SHALL cover: p1_req pulsed for 1 cycle while a p0 read is in RESP -> no p1_gnt ever issued.
